bus_counter: RTL and testbench



---
 rtl/bus_counter_pkg.sv | 29 ++
 rtl/bus_tristate.sv | 17 +
 rtl/bus_counter.sv | 100 ++++++++++
 tb/tb_bus_counter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bus_counter_pkg.sv
// Shared constants for bus-attached blocks of the breadboard-style CPU.
//
// Contents:
//   DIR_UP / DIR_DOWN     encoding of a counter direction input
//   MODE_WRAP / MODE_SAT  encoding of a terminal-count behaviour input
//   is_terminal()         terminal condition shared by all bus counters
package bus_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Terminal condition at a given count and limit. Counting up, any value
    // at or above the limit is terminal, so a count loaded above the limit
    // wraps or holds on its next step instead of running on.
    function automatic logic is_terminal(
        input logic        dir,
        input logic [31:0] cnt,
        input logic [31:0] lim
    );
        if (dir == DIR_DOWN) begin
            return (cnt == 32'd0);
        end
        return (cnt >= lim);
    endfunction

endpackage

// File: rtl/bus_tristate.sv
// Parametrised tristate driver for the shared data bus.
//
// Ports:
//   data  in     WIDTH  value to present on the bus
//   oe    in     1      output enable; bus is all-Z when low
//   bus   inout  WIDTH  shared data bus
module bus_tristate #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    input  logic             oe,
    inout  wire  [WIDTH-1:0] bus
);

    assign bus = oe ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/bus_counter.sv
// WIDTH-bit up/down bus counter with a programmable terminal limit and
// wrap or saturate behaviour at the terminal count.
//
// Ports:
//   clk       in     1      rising-edge clock
//   clr       in     1      synchronous active-high reset
//   bus       inout  WIDTH  shared data bus (loads come from it, out drives it)
//   load      in     1      capture bus into count
//   load_lim  in     1      capture bus into limit register
//   out       in     1      drive count onto bus
//   enable    in     1      count enable
//   down      in     1      direction, DIR_UP / DIR_DOWN
//   sat       in     1      terminal behaviour, MODE_WRAP / MODE_SAT
//   tc        out    1      terminal count flag (combinational)
//   wrap      out    1      one-cycle pulse the cycle after a wrap step
//   count     out    WIDTH  registered count, always driven
module bus_counter
    import bus_counter_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] LIM_RESET = WIDTH'((2 ** WIDTH) - 1)
) (
    input  logic             clk,
    input  logic             clr,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             load,
    input  logic             load_lim,
    input  logic             out,
    input  logic             enable,
    input  logic             down,
    input  logic             sat,
    output logic             tc,
    output logic             wrap,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lim_q,   lim_d;
    logic             wrap_q,  wrap_d;
    logic [WIDTH-1:0] bus_in;
    logic             term;

    // A self-load (load with out=1) reads back our own drive, so the count
    // is unchanged without any special casing.
    bus_tristate #(.WIDTH(WIDTH)) u_drv (
        .data (count_q),
        .oe   (out),
        .bus  (bus)
    );

    assign bus_in = bus;

    assign term = is_terminal(down, 32'(count_q), 32'(lim_q));

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        count_d = count_q;
        lim_d   = lim_q;
        wrap_d  = 1'b0;

        if (load) begin
            count_d = bus_in;
        end else if (enable) begin
            if (!term) begin
                count_d = (down == DIR_DOWN) ? count_q - WIDTH'(1)
                                             : count_q + WIDTH'(1);
            end else if (sat == MODE_WRAP) begin
                // Down-counting reloads from the limit; up-counting restarts
                // at zero. The old limit is used even if load_lim is high.
                count_d = (down == DIR_DOWN) ? lim_q : '0;
                wrap_d  = 1'b1;
            end
        end

        if (load_lim) begin
            lim_d = bus_in;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (clr) begin
            count_q <= RESET_VAL;
            lim_q   <= LIM_RESET;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            lim_q   <= lim_d;
            wrap_q  <= wrap_d;
        end
    end

    assign tc    = term;
    assign wrap  = wrap_q;
    assign count = count_q;

endmodule

// File: tb/tb_bus_counter.sv
// Self-checking bench for bus_counter (WIDTH=4, default reset values).
// Stimulus applies inputs on the falling edge, advances a behavioural model
// and queues the expected post-edge view; a monitor compares after each
// rising edge.
module tb_bus_counter;

    localparam int W    = 4;
    localparam int MODV = 1 << W;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic         load_lim = 1'b0;
    logic         out = 1'b0;
    logic         enable = 1'b0;
    logic         down = 1'b0;
    logic         sat = 1'b0;
    logic         tc;
    logic         wrap;
    logic [W-1:0] count;
    wire  [W-1:0] bus;

    logic         tb_oe = 1'b0;
    logic [W-1:0] tb_data = '0;

    assign bus = tb_oe ? tb_data : {W{1'bz}};

    bus_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .bus      (bus),
        .load     (load),
        .load_lim (load_lim),
        .out      (out),
        .enable   (enable),
        .down     (down),
        .sat      (sat),
        .tc       (tc),
        .wrap     (wrap),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cnt;
        bit    wrp;
        bit    term;
        bit    chk_bus;
        string tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 0;

    // Model state: plain integers, with the limit as the wrap-around point.
    int m_count = 0;
    int m_lim   = MODV - 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs, predict the result of the coming edge.
    task automatic step(input bit c, input bit ld, input bit ll, input bit o,
                        input bit en, input bit dn, input bit st,
                        input int ext, input string tag);
        int   busv, nc, nl;
        bit   nw;
        exp_t e;
        clr = c; load = ld; load_lim = ll; out = o;
        enable = en; down = dn; sat = st;
        tb_oe   = !o;
        tb_data = W'(ext);
        busv = o ? m_count : ext % MODV;
        nc = m_count; nl = m_lim; nw = 0;
        if (c) begin
            nc = 0; nl = MODV - 1;
        end else begin
            if (ld) nc = busv;
            else if (en) begin
                if (dn) begin
                    if (m_count != 0)  nc = m_count - 1;
                    else if (!st) begin nc = m_lim; nw = 1; end
                end else begin
                    if (m_count < m_lim) nc = (m_count + 1) % MODV;
                    else if (!st) begin nc = 0; nw = 1; end
                end
            end
            if (ll) nl = busv;
        end
        m_count = nc; m_lim = nl;
        e.cnt = nc; e.wrp = nw;
        e.term = dn ? (nc == 0) : (nc >= nl);
        e.chk_bus = o; e.tag = tag;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every rising edge presents a new registered result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.tag, ".count"}, int'(count), e.cnt);
                check({e.tag, ".wrap"},  int'(wrap),  int'(e.wrp));
                check({e.tag, ".tc"},    int'(tc),    int'(e.term));
                if (e.chk_bus) check({e.tag, ".bus"}, int'(bus), e.cnt);
            end
        end
    end

    initial begin
        // args: clr load load_lim out enable down sat ext tag
        step(1, 0, 0, 1, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 1, 0, 0, 0, "up16");

        step(0, 1, 0, 0, 0, 0, 0, 0,   "ld0");
        step(0, 0, 1, 0, 0, 0, 0, 9,   "lim9");
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 0, 1, 0, "sat9");
        for (int i = 0; i < 3; i++)  step(0, 0, 0, 1, 1, 0, 0, 0, "wrap9");

        step(0, 0, 1, 0, 0, 1, 0, 5,   "lim5");
        step(0, 1, 0, 0, 0, 1, 0, 1,   "ld1");
        for (int i = 0; i < 4; i++)  step(0, 0, 0, 1, 1, 1, 0, 0, "down");

        step(0, 0, 1, 0, 0, 0, 0, 9,   "lim9b");
        step(0, 1, 0, 0, 0, 0, 0, 12,  "ldC");
        step(0, 0, 0, 1, 1, 0, 0, 0,   "abovelim");

        step(0, 1, 0, 0, 0, 0, 0, 3,   "ext3");
        step(0, 1, 0, 1, 0, 0, 0, 0,   "selfload");
        step(0, 0, 0, 1, 1, 0, 0, 0,   "post_self");

        step(0, 0, 1, 0, 1, 0, 0, 2,   "limstep");
        step(0, 0, 0, 1, 1, 0, 0, 0,   "newlim");
        step(1, 1, 1, 0, 1, 0, 0, 7,   "clrmid");
        step(0, 0, 0, 1, 1, 0, 0, 0,   "resume");

        step(0, 0, 1, 0, 0, 0, 0, 0,   "lim0");
        for (int i = 0; i < 3; i++)  step(0, 0, 0, 1, 1, 0, 0, 0, "lim0w");
        step(0, 0, 0, 1, 1, 0, 1, 0,   "lim0s");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(39) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(9) == 0), 1'($urandom_range(1)),
                 ($urandom_range(3) != 0), 1'($urandom_range(1)),
                 1'($urandom_range(1)), int'($urandom_range(MODV - 1)), "rand");
        end
        stim_done = 1;
    end

    initial begin
        int waited;
        wait (stim_done);
        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
